// File: rtl/data_mem_if.sv
// Hold/unhold stall handshake between the control unit and the data-memory responder.
// The control unit drives the master side; the responder implements the slave side.
interface data_mem_if #(
  parameter int ADDR_W = 10
);
  logic              hold;
  logic              mem_read;
  logic              mem_write;
  logic [5:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic              unhold;
  logic [31:0]       rd_data;
  logic              busy;
  logic              err;

  modport master (
    output hold, mem_read, mem_write, op, addr, wr_data,
    input  unhold, rd_data, busy, err
  );

  modport slave (
    input  hold, mem_read, mem_write, op, addr, wr_data,
    output unhold, rd_data, busy, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one load/store per hold request, services it against
// an internal word RAM after a fixed latency, then pulses unhold to release the pipeline.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);

  localparam int         WORDS    = 2 ** (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [5:0] OP_LBD = 6'd10;
  localparam logic [5:0] OP_LDW = 6'd11;
  localparam logic [5:0] OP_STB = 6'd12;
  localparam logic [5:0] OP_STW = 6'd13;
  localparam logic [5:0] OP_MOV = 6'd14;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              err_q, err_d;

  logic [31:0]       ram_q [WORDS];
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_word;
  logic [1:0]        lane;

  logic rd_ok, wr_ok, accept, illegal, misaligned;

  assign ram_word = ram_q[addr_q[ADDR_W-1:2]];
  assign lane     = addr_q[1:0];

  // Exactly one qualifier, and an opcode that matches its direction.
  assign rd_ok      = bus.mem_read & ~bus.mem_write & (bus.op == OP_LBD || bus.op == OP_LDW);
  assign wr_ok      = bus.mem_write & ~bus.mem_read &
                      (bus.op == OP_STB || bus.op == OP_STW || bus.op == OP_MOV);
  assign accept     = bus.hold & (rd_ok | wr_ok);
  assign illegal    = bus.hold & (bus.mem_read | bus.mem_write) & ~accept;
  assign misaligned = (bus.op != OP_LBD) && (bus.op != OP_STB) && (bus.addr[1:0] != 2'b00);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = ram_word;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = bus.op;
          addr_d    = bus.addr;
          wr_data_d = bus.wr_data;
          cnt_d     = CNT_INIT;
          err_d     = misaligned;
          state_d   = S_BUSY;
        end else begin
          err_d = illegal;
        end
      end
      S_BUSY: begin
        // Dropping hold abandons the access; abort wins even on the final count.
        if (!bus.hold) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          unique case (op_q)
            OP_LBD: rd_data_d = {24'b0, ram_word[{lane, 3'b000} +: 8]};
            OP_LDW: rd_data_d = ram_word;
            OP_STB: begin
              ram_we                         = 1'b1;
              ram_wdata[{lane, 3'b000} +: 8] = wr_data_q[7:0];
            end
            default: begin
              ram_we    = 1'b1;
              ram_wdata = wr_data_q;
            end
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 6'd0;
      addr_q    <= '0;
      wr_data_q <= 32'd0;
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the RAM array has no reset; resetting storage would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[addr_q[ADDR_W-1:2]] <= ram_wdata;
  end

  assign bus.unhold  = (state_q == S_DONE);
  assign bus.busy    = (state_q == S_BUSY);
  assign bus.err     = err_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_W=10, LATENCY=3): reset, loads/stores,
// byte lanes, abort, illegal requests and back-to-back handshakes.
module tb_data_mem_responder;

  localparam logic [5:0] LBD = 6'd10;
  localparam logic [5:0] LDW = 6'd11;
  localparam logic [5:0] STB = 6'd12;
  localparam logic [5:0] STW = 6'd13;
  localparam logic [5:0] MOV = 6'd14;
  localparam int         EXP_LAT = 4;

  logic clk;
  logic rst_n;
  data_mem_if #(.ADDR_W(10)) bus ();

  data_mem_responder #(.ADDR_W(10), .LATENCY(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_v;
  int          lat_v;
  bit          err_v;
  bit          unh_after;

  // Issue one request from IDLE, hold until unhold, then step one cycle past DONE.
  task automatic do_req(input logic [5:0] op, input logic [9:0] a, input logic [31:0] wd,
                        input bit rd, input bit wr, output logic [31:0] data,
                        output int lat, output bit err_seen, output bit unh_next);
    bit got = 0;
    bus.hold = 1'b1; bus.mem_read = rd; bus.mem_write = wr;
    bus.op = op; bus.addr = a; bus.wr_data = wd;
    lat = 0; err_seen = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.err) err_seen = 1;
      if (bus.unhold) got = 1;
      if (lat == 1) begin
        bus.op = 6'd0; bus.addr = '0; bus.wr_data = '0;
      end
    end
    data = bus.rd_data;
    bus.hold = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(posedge clk); #1;
    unh_next = bus.unhold;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.unhold !== 1'b0) begin n_fail++; $display("FAIL reset_unhold: got %b want 0", bus.unhold); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_checks++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(STW, 10'h010, 32'hCAFEF00D, 0, 1, rd_v, lat_v, err_v, unh_after);

    // Reset in the middle of a second store to the same word.
    bus.hold = 1'b1; bus.mem_write = 1'b1; bus.op = STW; bus.addr = 10'h010; bus.wr_data = 32'h11111111;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b want 1", bus.busy); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.unhold !== 1'b0) begin n_fail++; $display("FAIL midreset_unhold: got %b want 0", bus.unhold); end
    n_checks++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL midreset_rd_data: got %h want 0", bus.rd_data); end
    bus.hold = 1'b0; bus.mem_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req(LDW, 10'h010, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (rd_v !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midreset_word_kept: got %h want cafef00d", rd_v); end
  endtask

  task automatic test_store_load();
    do_req(STW, 10'h020, 32'hDEADBEEF, 0, 1, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (lat_v !== EXP_LAT) begin n_fail++; $display("FAIL stw_latency: got %0d want %0d", lat_v, EXP_LAT); end
    n_checks++; if (rd_v !== 32'hCAFEF00D) begin n_fail++; $display("FAIL stw_rd_data_kept: got %h want cafef00d", rd_v); end
    n_checks++; if (unh_after !== 1'b0) begin n_fail++; $display("FAIL stw_unhold_width: got %b want 0", unh_after); end
    n_checks++; if (err_v !== 1'b0) begin n_fail++; $display("FAIL stw_err: got %b want 0", err_v); end
    do_req(LDW, 10'h020, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (lat_v !== EXP_LAT) begin n_fail++; $display("FAIL ldw_latency: got %0d want %0d", lat_v, EXP_LAT); end
    n_checks++; if (rd_v !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldw_data: got %h want deadbeef", rd_v); end
  endtask

  task automatic test_byte_lanes();
    do_req(STB, 10'h021, 32'hAAAAAA55, 0, 1, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (err_v !== 1'b0) begin n_fail++; $display("FAIL stb_err: got %b want 0", err_v); end
    do_req(LDW, 10'h020, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (rd_v !== 32'hDEAD55EF) begin n_fail++; $display("FAIL stb_merge: got %h want dead55ef", rd_v); end
    do_req(LBD, 10'h023, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (rd_v !== 32'h000000DE) begin n_fail++; $display("FAIL lbd_lane3: got %h want 000000de", rd_v); end
    do_req(LBD, 10'h020, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (rd_v !== 32'h000000EF) begin n_fail++; $display("FAIL lbd_lane0: got %h want 000000ef", rd_v); end
  endtask

  task automatic test_mov_misaligned();
    do_req(MOV, 10'h041, 32'h0F0F1234, 0, 1, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (err_v !== 1'b1) begin n_fail++; $display("FAIL mov_misaligned_err: got %b want 1", err_v); end
    n_checks++; if (lat_v !== EXP_LAT) begin n_fail++; $display("FAIL mov_latency: got %0d want %0d", lat_v, EXP_LAT); end
    do_req(LDW, 10'h040, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (rd_v !== 32'h0F0F1234) begin n_fail++; $display("FAIL mov_data: got %h want 0f0f1234", rd_v); end
  endtask

  task automatic test_abort();
    bit unh_seen = 0;
    do_req(STW, 10'h030, 32'h0BADF00D, 0, 1, rd_v, lat_v, err_v, unh_after);
    bus.hold = 1'b1; bus.mem_write = 1'b1; bus.op = STW; bus.addr = 10'h030; bus.wr_data = 32'h12345678;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_rise: got %b want 1", bus.busy); end
    bus.hold = 1'b0; bus.mem_write = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_fall: got %b want 0", bus.busy); end
    for (int i = 0; i < 6; i++) begin
      if (bus.unhold) unh_seen = 1;
      @(posedge clk); #1;
    end
    n_checks++; if (unh_seen !== 1'b0) begin n_fail++; $display("FAIL abort_unhold: got %b want 0", unh_seen); end
    do_req(LDW, 10'h030, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (rd_v !== 32'h0BADF00D) begin n_fail++; $display("FAIL abort_no_write: got %h want 0badf00d", rd_v); end
  endtask

  task automatic test_illegal();
    bus.hold = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.op = LDW; bus.addr = 10'h020;
    @(posedge clk); #1;
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL both_qual_err: got %b want 1", bus.err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL both_qual_busy: got %b want 0", bus.busy); end
    bus.hold = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL both_qual_err_width: got %b want 0", bus.err); end

    bus.hold = 1'b1; bus.mem_read = 1'b1; bus.op = STB; bus.addr = 10'h020; bus.wr_data = 32'h000000FF;
    @(posedge clk); #1;
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL dir_mismatch_err: got %b want 1", bus.err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dir_mismatch_busy: got %b want 0", bus.busy); end
    bus.hold = 1'b0; bus.mem_read = 1'b0;
    @(posedge clk); #1;

    bus.hold = 1'b1; bus.op = LDW;
    @(posedge clk); #1;
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL no_qual_err: got %b want 0", bus.err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL no_qual_busy: got %b want 0", bus.busy); end
    bus.hold = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.rd_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL illegal_rd_data_kept: got %h want 0badf00d", bus.rd_data); end
    do_req(LDW, 10'h020, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (rd_v !== 32'hDEAD55EF) begin n_fail++; $display("FAIL illegal_no_access: got %h want dead55ef", rd_v); end
  endtask

  task automatic test_back_to_back();
    do_req(STW, 10'h000, 32'hA5A50001, 0, 1, rd_v, lat_v, err_v, unh_after);
    do_req(STW, 10'h3FC, 32'h5A5A03FC, 0, 1, rd_v, lat_v, err_v, unh_after);
    do_req(LDW, 10'h000, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (rd_v !== 32'hA5A50001) begin n_fail++; $display("FAIL b2b_first_data: got %h want a5a50001", rd_v); end
    n_checks++; if (unh_after !== 1'b0) begin n_fail++; $display("FAIL b2b_unhold_width: got %b want 0", unh_after); end
    do_req(LDW, 10'h3FC, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (lat_v !== EXP_LAT) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", lat_v, EXP_LAT); end
    n_checks++; if (rd_v !== 32'h5A5A03FC) begin n_fail++; $display("FAIL b2b_top_word: got %h want 5a5a03fc", rd_v); end
    do_req(LDW, 10'h002, 32'd0, 1, 0, rd_v, lat_v, err_v, unh_after);
    n_checks++; if (err_v !== 1'b1) begin n_fail++; $display("FAIL ldw_misaligned_err: got %b want 1", err_v); end
    n_checks++; if (rd_v !== 32'hA5A50001) begin n_fail++; $display("FAIL ldw_misaligned_data: got %h want a5a50001", rd_v); end
  endtask

  initial begin
    bus.hold = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.op = 6'd0; bus.addr = '0; bus.wr_data = 32'd0;
    rst_n = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_mov_misaligned();
    test_abort();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
